// File: rtl/radar_chirp_gen_if.sv
// Sweep-control bundle between the chirp generator and its host/NCO side.
// The master drives the sweep programming; the slave returns the NCO frequency word and status.
interface radar_chirp_gen_if #(
  parameter int CNT_W = 16
);
  logic             ena_i;
  logic             strobe_i;
  logic             mode_i;
  logic [31:0]      fstart_i;
  logic [31:0]      fincr_i;
  logic [CNT_W-1:0] ulen_i;
  logic [CNT_W-1:0] wlen_i;
  logic [31:0]      freq_o;
  logic             tx_ena_o;
  logic             sweep_o;
  logic [1:0]       state_o;

  modport master (
    output ena_i, strobe_i, mode_i, fstart_i, fincr_i, ulen_i, wlen_i,
    input  freq_o, tx_ena_o, sweep_o, state_o
  );

  modport slave (
    input  ena_i, strobe_i, mode_i, fstart_i, fincr_i, ulen_i, wlen_i,
    output freq_o, tx_ena_o, sweep_o, state_o
  );
endinterface

// File: rtl/radar_chirp_gen.sv
// FMCW sweep controller: sawtooth/triangle frequency ramps with a quiet interval,
// advancing one step per sample strobe and feeding the transmit NCO.
module radar_chirp_gen #(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  radar_chirp_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      freq;
  logic             tx_ena;
  logic             sweep;

  // Sweep parameters are frozen for the whole sweep so host writes never tear a ramp.
  logic [31:0]      fstart_s;
  logic [31:0]      fincr_s;
  logic [CNT_W-1:0] ulen_s;
  logic [CNT_W-1:0] wlen_s;
  logic             mode_s;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      freq     <= '0;
      tx_ena   <= 1'b0;
      sweep    <= 1'b0;
      fstart_s <= '0;
      fincr_s  <= '0;
      ulen_s   <= '0;
      wlen_s   <= '0;
      mode_s   <= 1'b0;
    end else begin
      sweep <= 1'b0;
      if (!bus.ena_i) begin
        // Abort wins over any coincident strobe.
        state  <= S_IDLE;
        cnt    <= '0;
        freq   <= '0;
        tx_ena <= 1'b0;
      end else if (bus.strobe_i) begin
        unique case (state)
          S_IDLE: begin
            fstart_s <= bus.fstart_i;
            fincr_s  <= bus.fincr_i;
            ulen_s   <= bus.ulen_i;
            wlen_s   <= bus.wlen_i;
            mode_s   <= bus.mode_i;
            freq     <= bus.fstart_i;
            sweep    <= 1'b1;
            tx_ena   <= 1'b1;
            cnt      <= '0;
            state    <= S_UP;
          end
          S_UP: begin
            if (cnt == ulen_s) begin
              cnt <= '0;
              if (mode_s) begin
                state <= S_DOWN;
              end else begin
                state  <= S_WAIT;
                tx_ena <= 1'b0;
              end
            end else begin
              freq <= freq + fincr_s;
              cnt  <= cnt + CNT_W'(1);
            end
          end
          S_DOWN: begin
            if (cnt == ulen_s) begin
              cnt    <= '0;
              state  <= S_WAIT;
              tx_ena <= 1'b0;
            end else begin
              freq <= freq - fincr_s;
              cnt  <= cnt + CNT_W'(1);
            end
          end
          S_WAIT: begin
            if (cnt == wlen_s) begin
              fstart_s <= bus.fstart_i;
              fincr_s  <= bus.fincr_i;
              ulen_s   <= bus.ulen_i;
              wlen_s   <= bus.wlen_i;
              mode_s   <= bus.mode_i;
              freq     <= bus.fstart_i;
              sweep    <= 1'b1;
              tx_ena   <= 1'b1;
              cnt      <= '0;
              state    <= S_UP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.freq_o   = freq;
  assign bus.tx_ena_o = tx_ena;
  assign bus.sweep_o  = sweep;
  assign bus.state_o  = state;

endmodule
